// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared encodings for the load/store unit: store/load type codes, FSM states,
// base write-strobe masks and the captured-op record.
// No ports. Imported by ysyx_22041211_lsu, ysyx_22041211_lsu_fmt and the bus interface users.
package ysyx_22041211_lsu_pkg;

  localparam int XLEN = 32;

  // store_type encodings
  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] STORE_SB   = 2'd1;
  localparam logic [1:0] STORE_SH   = 2'd2;
  localparam logic [1:0] STORE_SW   = 2'd3;

  // load_type encodings; 6 and 7 are undefined and behave as LOAD_NONE
  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LH   = 3'd2;
  localparam logic [2:0] LOAD_LW   = 3'd3;
  localparam logic [2:0] LOAD_LBU  = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;

  // base strobe masks, shifted left by the byte offset
  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // op captured on acceptance; load_type is already normalised
  // (forced to LOAD_NONE for stores and for codes 6/7)
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      store_type;
    logic [2:0]      load_type;
    logic            wd;
    logic [4:0]      wreg;
  } meta_t;

endpackage

// File: rtl/ysyx_22041211_lsu_if.sv
// Single-beat valid/ready data-memory bus between the LSU (master) and memory (slave).
// Request: req_valid_o/req_ready_i, req_addr_o, req_wen_o, req_wstrb_o, req_wdata_o.
// Response: rsp_valid_i/rsp_ready_o, rsp_rdata_i. Suffixes are relative to the LSU.
interface ysyx_22041211_lsu_if #(
  parameter int DATA_LEN = 32
);
  logic                req_valid_o;
  logic                req_ready_i;
  logic [DATA_LEN-1:0] req_addr_o;
  logic                req_wen_o;
  logic [3:0]          req_wstrb_o;
  logic [DATA_LEN-1:0] req_wdata_o;
  logic                rsp_valid_i;
  logic [DATA_LEN-1:0] rsp_rdata_i;
  logic                rsp_ready_o;

  modport master (
    output req_valid_o, req_addr_o, req_wen_o, req_wstrb_o, req_wdata_o, rsp_ready_o,
    input  req_ready_i, rsp_valid_i, rsp_rdata_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, req_wen_o, req_wstrb_o, req_wdata_o, rsp_ready_o,
    output req_ready_i, rsp_valid_i, rsp_rdata_i
  );
endinterface

// File: rtl/ysyx_22041211_lsu_fmt.sv
// Lane formatter: store strobes + replicated store data, and extended load data.
// Latency: purely combinational (0 cycles).
// Backpressure: none; outputs follow inputs.
// Ports: store_type_i/load_type_i (codes), off_i (addr[1:0]), wdata_i (store data in
// low bits), rdata_i (full read word) -> wstrb_o, wdata_o, ldata_o.
module ysyx_22041211_lsu_fmt
  import ysyx_22041211_lsu_pkg::*;
(
  input  logic [1:0]      store_type_i,
  input  logic [2:0]      load_type_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // half select only looks at off[1]; an odd half offset reads the
  // enclosing aligned half rather than straddling lanes
  assign byte_sel = rdata_i[8*off_i +: 8];
  assign half_sel = rdata_i[16*off_i[1] +: 16];

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = '0;
    case (store_type_i)
      // shifting a 4-bit mask drops strobes that fall past lane 3
      STORE_SB: begin wstrb_o = WSTRB_B << off_i; wdata_o = {4{wdata_i[7:0]}};  end
      STORE_SH: begin wstrb_o = WSTRB_H << off_i; wdata_o = {2{wdata_i[15:0]}}; end
      STORE_SW: begin wstrb_o = WSTRB_W;          wdata_o = wdata_i;            end
      default:  ;
    endcase
  end

  always_comb begin
    ldata_o = '0;
    case (load_type_i)
      LOAD_LB:  ldata_o = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LH:  ldata_o = {{16{half_sel[15]}}, half_sel};
      LOAD_LW:  ldata_o = rdata_i;
      LOAD_LBU: ldata_o = {24'd0, byte_sel};
      LOAD_LHU: ldata_o = {16'd0, half_sel};
      default:  ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit between EXE and WB: one op in flight, single-beat memory access.
// Latency: non-memory op -> wb_valid_o the cycle after acceptance; memory op >= 3 cycles.
// Backpressure: in_ready_o only in IDLE; request held until req_ready_i; result held until wb_ready_i.
// Ports: clk/rst (async, active-high); EXE side in_valid_i/in_ready_o, addr_i, mem_wdata_i,
// store_type_i, load_type_i, wd_i, wreg_i; memory bus via ysyx_22041211_lsu_if.master;
// WB side wb_valid_o/wb_ready_i, wb_data_o, wd_o, wreg_o, misalign_o.
// Optional: define YSYX_22041211_MISALIGN_CHECK_EN to trap misaligned half/word accesses
// (no bus request, misalign_o=1); otherwise misalign_o is constant 0. Only DATA_LEN=32 is supported.
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [1:0]          store_type_i,
  input  logic [2:0]          load_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  ysyx_22041211_lsu_if.master mem,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [DATA_LEN-1:0] wb_data_o,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic                misalign_o
);

  lsu_state_e      state_q, state_d;
  meta_t           op_q;
  logic [XLEN-1:0] result_q;
  logic            misalign_q;

  logic [2:0]      load_eff;
  logic            is_mem;
  logic            misalign_in;
  logic [3:0]      fmt_wstrb;
  logic [XLEN-1:0] fmt_wdata;
  logic [XLEN-1:0] fmt_ldata;

  // stores win over loads; undefined load codes collapse to none
  assign load_eff = (store_type_i != STORE_NONE || load_type_i > LOAD_LHU) ? LOAD_NONE
                                                                           : load_type_i;
  assign is_mem   = (store_type_i != STORE_NONE) || (load_eff != LOAD_NONE);

`ifdef YSYX_22041211_MISALIGN_CHECK_EN
  always_comb begin
    misalign_in = 1'b0;
    if (store_type_i == STORE_SH || load_eff == LOAD_LH || load_eff == LOAD_LHU)
      misalign_in = addr_i[0];
    else if (store_type_i == STORE_SW || load_eff == LOAD_LW)
      misalign_in = (addr_i[1:0] != 2'b00);
  end
`else
  assign misalign_in = 1'b0;
`endif

  ysyx_22041211_lsu_fmt u_fmt (
    .store_type_i (op_q.store_type),
    .load_type_i  (op_q.load_type),
    .off_i        (op_q.addr[1:0]),
    .wdata_i      (op_q.wdata),
    .rdata_i      (mem.rsp_rdata_i),
    .wstrb_o      (fmt_wstrb),
    .wdata_o      (fmt_wdata),
    .ldata_o      (fmt_ldata)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (in_valid_i)      state_d = (is_mem && !misalign_in) ? LSU_REQ : LSU_DONE;
      LSU_REQ:  if (mem.req_ready_i) state_d = LSU_WAIT;
      LSU_WAIT: if (mem.rsp_valid_i) state_d = LSU_DONE;
      LSU_DONE: if (wb_ready_i)      state_d = LSU_IDLE;
      default:                       state_d = LSU_IDLE;
    endcase
  end

  // outputs; request fields are zero outside REQ so a reset clears them at once
  always_comb begin
    in_ready_o      = 1'b0;
    mem.req_valid_o = 1'b0;
    mem.req_addr_o  = '0;
    mem.req_wen_o   = 1'b0;
    mem.req_wstrb_o = 4'b0000;
    mem.req_wdata_o = '0;
    mem.rsp_ready_o = 1'b0;
    wb_valid_o      = 1'b0;
    case (state_q)
      LSU_IDLE: in_ready_o = 1'b1;
      LSU_REQ: begin
        mem.req_valid_o = 1'b1;
        mem.req_addr_o  = {op_q.addr[XLEN-1:2], 2'b00};
        mem.req_wen_o   = (op_q.store_type != STORE_NONE);
        mem.req_wstrb_o = fmt_wstrb;
        mem.req_wdata_o = fmt_wdata;
      end
      LSU_WAIT: mem.rsp_ready_o = 1'b1;
      LSU_DONE: wb_valid_o      = 1'b1;
      default:  ;
    endcase
  end

  // op capture and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: if (in_valid_i) begin
          op_q.addr       <= addr_i;
          op_q.wdata      <= mem_wdata_i;
          op_q.store_type <= store_type_i;
          op_q.load_type  <= load_eff;
          op_q.wd         <= wd_i;
          op_q.wreg       <= wreg_i;
          // memory ops (including trapped ones) start from 0; others pass addr through
          result_q        <= is_mem ? '0 : addr_i;
          misalign_q      <= misalign_in;
        end
        // stores carry LOAD_NONE, so the formatter yields 0 for them
        LSU_WAIT: if (mem.rsp_valid_i) result_q <= fmt_ldata;
        LSU_DONE: if (wb_ready_i) misalign_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign wb_data_o  = result_q;
  assign wd_o       = op_q.wd;
  assign wreg_o     = op_q.wreg;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed-vector scoreboard bench for ysyx_22041211_lsu.
module tb_ysyx_22041211_lsu;
  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] addr_i;
  logic [31:0] mem_wdata_i;
  logic [1:0]  store_type_i;
  logic [2:0]  load_type_i;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_data_o;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic        misalign_o;

  ysyx_22041211_lsu_if #(.DATA_LEN(32)) mem_if ();

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .addr_i       (addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .store_type_i (store_type_i),
    .load_type_i  (load_type_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .mem          (mem_if),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_data_o    (wb_data_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .misalign_o   (misalign_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       nm;
    logic [31:0] a, d;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic        wd;
    logic [4:0]  wr;
    logic [31:0] rdata;
    int          rd, rsp, wbd;   // req_ready stall, response delay, wb_ready stall (cycles)
    bit          hr;             // a bus request is expected
    logic [31:0] ea;
    logic        ew;
    logic [3:0]  es;
    logic [31:0] ed;
    logic [31:0] ewb;
    logic        em;
    int          lat;            // cycles from acceptance to first wb_valid_o
  } vec_t;

  vec_t exp_req_q[$];
  vec_t exp_wb_q[$];
  vec_t vecs[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic void check(input string what, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endfunction

  function automatic void timeout(input string what);
    n_cmp++;
    n_err++;
    $display("FAIL timeout waiting for %s: got no event, expected one within 50 cycles", what);
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] st, input logic [2:0] lt, input logic wd,
                              input logic [4:0] wr, input logic [31:0] rdata, input int rd,
                              input int rsp, input int wbd, input bit hr, input logic [31:0] ea,
                              input logic ew, input logic [3:0] es, input logic [31:0] ed,
                              input logic [31:0] ewb, input logic em, input int lat);
    vec_t v;
    v.nm = nm; v.a = a; v.d = d; v.st = st; v.lt = lt; v.wd = wd; v.wr = wr;
    v.rdata = rdata; v.rd = rd; v.rsp = rsp; v.wbd = wbd; v.hr = hr;
    v.ea = ea; v.ew = ew; v.es = es; v.ed = ed; v.ewb = ewb; v.em = em; v.lat = lat;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic        busy = 1'b0;
  logic        first_wb = 1'b0;
  logic        inready_bad = 1'b0;
  int          acc_cyc = 0;
  int          req_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [69:0] held_req = '0;
  logic [69:0] cur_req;
  vec_t        e;

  always @(negedge clk) begin
    if (rst) begin
      busy       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (busy && in_ready_o) inready_bad = 1'b1;
      if (in_valid_i && in_ready_o) begin
        busy = 1'b1; first_wb = 1'b1; inready_bad = 1'b0;
        acc_cyc = cyc; req_cnt = 0;
      end

      cur_req = {mem_if.req_valid_o, mem_if.req_addr_o, mem_if.req_wen_o,
                 mem_if.req_wstrb_o, mem_if.req_wdata_o};
      if (prev_stall) check("req held stable under stall", 96'(cur_req), 96'(held_req));
      prev_stall = mem_if.req_valid_o && !mem_if.req_ready_i;
      held_req   = cur_req;

      if (mem_if.req_valid_o && mem_if.req_ready_i) begin
        req_cnt++;
        if (exp_req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected request: got addr %0h, expected no request", mem_if.req_addr_o);
        end else begin
          e = exp_req_q.pop_front();
          check({e.nm, " req_addr"},  96'(mem_if.req_addr_o),  96'(e.ea));
          check({e.nm, " req_wen"},   96'(mem_if.req_wen_o),   96'(e.ew));
          check({e.nm, " req_wstrb"}, 96'(mem_if.req_wstrb_o), 96'(e.es));
          if (e.ew) check({e.nm, " req_wdata"}, 96'(mem_if.req_wdata_o), 96'(e.ed));
        end
      end

      if (busy && wb_valid_o && first_wb) begin
        first_wb = 1'b0;
        if (exp_wb_q.size() != 0)
          check({exp_wb_q[0].nm, " latency"}, 96'(cyc - acc_cyc), 96'(exp_wb_q[0].lat));
      end

      if (wb_valid_o && wb_ready_i) begin
        if (exp_wb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected wb: got data %0h, expected no result", wb_data_o);
        end else begin
          e = exp_wb_q.pop_front();
          check({e.nm, " wb_data"},   96'(wb_data_o),  96'(e.ewb));
          check({e.nm, " wd"},        96'(wd_o),       96'(e.wd));
          check({e.nm, " wreg"},      96'(wreg_o),     96'(e.wr));
          check({e.nm, " misalign"},  96'(misalign_o), 96'(e.em));
          check({e.nm, " req count"}, 96'(req_cnt),    96'(e.hr));
          check({e.nm, " in_ready low while busy"}, 96'(inready_bad), 96'(1'b0));
        end
        busy = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    int n;
    if (v.hr) exp_req_q.push_back(v);
    exp_wb_q.push_back(v);
    addr_i = v.a; mem_wdata_i = v.d; store_type_i = v.st; load_type_i = v.lt;
    wd_i = v.wd; wreg_i = v.wr; in_valid_i = 1'b1;
    if (v.hr && v.rd == 0) mem_if.req_ready_i = 1'b1;
    wait_cycle();
    // scramble inputs so later use of them instead of the captured copy shows up
    in_valid_i = 1'b0; addr_i = 32'hDEAD_BEEF; mem_wdata_i = 32'hFFFF_FFFF;
    store_type_i = 2'd0; load_type_i = 3'd0; wd_i = ~v.wd; wreg_i = ~v.wr;
    if (v.hr) begin
      n = 0;
      while (!mem_if.req_valid_o && n < 50) begin wait_cycle(); n++; end
      if (!mem_if.req_valid_o) timeout({v.nm, " req_valid"});
      if (v.rd > 0) begin
        // a response offered during REQ must be ignored
        mem_if.rsp_valid_i = 1'b1; mem_if.rsp_rdata_i = 32'hBAD0_BAD0;
        repeat (v.rd) wait_cycle();
        mem_if.rsp_valid_i = 1'b0; mem_if.rsp_rdata_i = 32'h0;
      end
      mem_if.req_ready_i = 1'b1;
      wait_cycle();
      mem_if.req_ready_i = 1'b0;
      repeat (v.rsp) wait_cycle();
      mem_if.rsp_valid_i = 1'b1; mem_if.rsp_rdata_i = v.rdata;
      n = 0;
      while (!mem_if.rsp_ready_o && n < 50) begin wait_cycle(); n++; end
      if (!mem_if.rsp_ready_o) timeout({v.nm, " rsp_ready"});
      wait_cycle();
      mem_if.rsp_valid_i = 1'b0; mem_if.rsp_rdata_i = 32'h0;
    end
    n = 0;
    while (!wb_valid_o && n < 50) begin wait_cycle(); n++; end
    if (!wb_valid_o) timeout({v.nm, " wb_valid"});
    repeat (v.wbd) wait_cycle();
    wb_ready_i = 1'b1;
    wait_cycle();
    wb_ready_i = 1'b0;
    if (v.em) check({v.nm, " misalign cleared after DONE"}, 96'(misalign_o), 96'(1'b0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready_o"},  96'(in_ready_o),         96'(1'b1));
    check({tag, " req_valid_o"}, 96'(mem_if.req_valid_o), 96'(1'b0));
    check({tag, " req_addr_o"},  96'(mem_if.req_addr_o),  96'(32'h0));
    check({tag, " req_wen_o"},   96'(mem_if.req_wen_o),   96'(1'b0));
    check({tag, " req_wstrb_o"}, 96'(mem_if.req_wstrb_o), 96'(4'h0));
    check({tag, " req_wdata_o"}, 96'(mem_if.req_wdata_o), 96'(32'h0));
    check({tag, " rsp_ready_o"}, 96'(mem_if.rsp_ready_o), 96'(1'b0));
    check({tag, " wb_valid_o"},  96'(wb_valid_o),         96'(1'b0));
    check({tag, " wb_data_o"},   96'(wb_data_o),          96'(32'h0));
    check({tag, " wd_o"},        96'(wd_o),               96'(1'b0));
    check({tag, " wreg_o"},      96'(wreg_o),             96'(5'h0));
    check({tag, " misalign_o"},  96'(misalign_o),         96'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; in_valid_i = 1'b0; addr_i = '0; mem_wdata_i = '0; store_type_i = '0;
    load_type_i = '0; wd_i = 1'b0; wreg_i = '0; wb_ready_i = 1'b0;
    mem_if.req_ready_i = 1'b0; mem_if.rsp_valid_i = 1'b0; mem_if.rsp_rdata_i = '0;
    #1 rst = 1'b1;
    #1 check_idle("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_cycle();

    //        name        addr          data          st    lt    wd    wr     rdata        rd rsp wbd hr  req_addr      wen   wstrb    wdata         wb_data       mis   lat
    vecs.push_back(mk("sb_off3",  32'h8000_0003, 32'h0000_00A5, 2'd1, 3'd0, 1'b1, 5'd7,  32'h0,         0, 0, 0, 1, 32'h8000_0000, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0,         1'b0, 3));
    vecs.push_back(mk("lb_off2",  32'h8000_0102, 32'hCAFE_BABE, 2'd0, 3'd1, 1'b1, 5'd10, 32'h12F4_5678, 0, 0, 0, 1, 32'h8000_0100, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FFF4, 1'b0, 3));
    vecs.push_back(mk("lbu_off2", 32'h8000_0102, 32'hCAFE_BABE, 2'd0, 3'd4, 1'b1, 5'd11, 32'h12F4_5678, 0, 0, 0, 1, 32'h8000_0100, 1'b0, 4'b0000, 32'h0,         32'h0000_00F4, 1'b0, 3));
    vecs.push_back(mk("lh_off2",  32'h8000_0202, 32'h0,         2'd0, 3'd2, 1'b1, 5'd12, 32'h8001_0000, 0, 0, 0, 1, 32'h8000_0200, 1'b0, 4'b0000, 32'h0,         32'hFFFF_8001, 1'b0, 3));
    vecs.push_back(mk("lhu_off2", 32'h8000_0202, 32'h0,         2'd0, 3'd5, 1'b1, 5'd13, 32'h8001_0000, 0, 0, 0, 1, 32'h8000_0200, 1'b0, 4'b0000, 32'h0,         32'h0000_8001, 1'b0, 3));
    vecs.push_back(mk("nonmem",   32'h0000_1234, 32'h0,         2'd0, 3'd0, 1'b1, 5'd5,  32'h0,         0, 0, 0, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_1234, 1'b0, 1));
    vecs.push_back(mk("sh_bp",    32'h8000_0302, 32'h1111_BEEF, 2'd2, 3'd0, 1'b0, 5'd3,  32'h0,         3, 2, 2, 1, 32'h8000_0300, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0, 8));
    vecs.push_back(mk("lw",       32'h8000_0400, 32'h0,         2'd0, 3'd3, 1'b1, 5'd31, 32'hDEAD_BEEF, 0, 1, 0, 1, 32'h8000_0400, 1'b0, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 4));
    vecs.push_back(mk("sw",       32'h8000_0504, 32'h0123_4567, 2'd3, 3'd0, 1'b0, 5'd1,  32'h0,         0, 0, 1, 1, 32'h8000_0504, 1'b1, 4'b1111, 32'h0123_4567, 32'h0,         1'b0, 3));
    vecs.push_back(mk("sb_prio",  32'h8000_0601, 32'h0000_005A, 2'd1, 3'd1, 1'b0, 5'd2,  32'hFFFF_FFFF, 0, 0, 0, 1, 32'h8000_0600, 1'b1, 4'b0010, 32'h5A5A_5A5A, 32'h0,         1'b0, 3));
    vecs.push_back(mk("lt6_none", 32'hABCD_0000, 32'h0,         2'd0, 3'd6, 1'b1, 5'd9,  32'h0,         0, 0, 0, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'hABCD_0000, 1'b0, 1));
    vecs.push_back(mk("lh_off0",  32'h8000_0700, 32'h0,         2'd0, 3'd2, 1'b1, 5'd14, 32'h1234_F00D, 0, 0, 0, 1, 32'h8000_0700, 1'b0, 4'b0000, 32'h0,         32'hFFFF_F00D, 1'b0, 3));
`ifdef YSYX_22041211_MISALIGN_CHECK_EN
    vecs.push_back(mk("lw_mis",   32'h8000_0801, 32'h0,         2'd0, 3'd3, 1'b1, 5'd15, 32'h0,         0, 0, 0, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1));
    vecs.push_back(mk("sh_mis",   32'h8000_0901, 32'h0000_BEEF, 2'd2, 3'd0, 1'b0, 5'd16, 32'h0,         0, 0, 1, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1));
`else
    vecs.push_back(mk("sh_off3",  32'h8000_0803, 32'h0000_BEEF, 2'd2, 3'd0, 1'b0, 5'd15, 32'h0,         0, 0, 0, 1, 32'h8000_0800, 1'b1, 4'b1000, 32'hBEEF_BEEF, 32'h0,         1'b0, 3));
    vecs.push_back(mk("lh_off3",  32'h8000_0903, 32'h0,         2'd0, 3'd2, 1'b1, 5'd16, 32'h8001_0000, 0, 0, 0, 1, 32'h8000_0900, 1'b0, 4'b0000, 32'h0,         32'hFFFF_8001, 1'b0, 3));
`endif

    foreach (vecs[i]) drive(vecs[i]);

    // reset while a load waits for its response
    exp_req_q.push_back(mk("lw_rst", 32'h8000_0A00, 32'h0, 2'd0, 3'd3, 1'b1, 5'd9, 32'h0,
                           0, 0, 0, 1, 32'h8000_0A00, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 3));
    addr_i = 32'h8000_0A00; load_type_i = 3'd3; wd_i = 1'b1; wreg_i = 5'd9;
    in_valid_i = 1'b1; mem_if.req_ready_i = 1'b1;
    wait_cycle();
    in_valid_i = 1'b0; load_type_i = 3'd0;
    wait_cycle();
    mem_if.req_ready_i = 1'b0;
    check("rst_wait in WAIT rsp_ready_o", 96'(mem_if.rsp_ready_o), 96'(1'b1));
    #2 rst = 1'b1;
    #1 check_idle("rst_wait");
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycle();
    drive(mk("after_rst", 32'h0000_5678, 32'h0, 2'd0, 3'd0, 1'b0, 5'd4, 32'h0,
             0, 0, 0, 0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_5678, 1'b0, 1));

    repeat (3) wait_cycle();
    check("leftover expected requests", 96'(exp_req_q.size()), 96'(0));
    check("leftover expected results",  96'(exp_wb_q.size()),  96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
